systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl_if.sv | 38 +++
 rtl/systolic_ctrl.sv | 148 ++++++++++++++
 tb/tb_systolic_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_ctrl_if.sv
// Job/row handshake bundle between a job issuer and systolic_ctrl.
// Latency: none, wires only.
// Backpressure: b_ready_o / a_ready_o from the controller gate B and A row beats.
interface systolic_ctrl_if #(
  parameter int N        = 4,
  parameter int NUM_BITS = 8
);
  logic                           start_i;
  logic                           reload_i;
  logic                           acc_i;
  logic                           b_valid_i;
  logic                           b_ready_o;
  logic [N-1:0][NUM_BITS-1:0]     b_row_i;
  logic                           a_valid_i;
  logic                           a_ready_o;
  logic [N-1:0][NUM_BITS-1:0]     a_row_i;
  logic [N-1:0][NUM_BITS-1:0]     north_o;
  logic [N-1:0][NUM_BITS-1:0]     west_o;
  logic                           array_clr_o;
  logic                           busy_o;
  logic                           done_o;

  // Job issuer side: drives commands and rows, observes readies and array feeds.
  modport master (
    output start_i, reload_i, acc_i,
    output b_valid_i, b_row_i, a_valid_i, a_row_i,
    input  b_ready_o, a_ready_o,
    input  north_o, west_o, array_clr_o, busy_o, done_o
  );

  // Controller side.
  modport slave (
    input  start_i, reload_i, acc_i,
    input  b_valid_i, b_row_i, a_valid_i, a_row_i,
    output b_ready_o, a_ready_o,
    output north_o, west_o, array_clr_o, busy_o, done_o
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Systolic array controller: loads B weights north, streams skewed A rows west, drains, signals done.
// Latency: north_o 1 cycle after a B accept; west_o[i] i+1 cycles after an A accept; done DRAIN_CYC+1 after last A.
// Backpressure: b_ready_o only in LOAD, a_ready_o only in STREAM; a_valid_i low in STREAM inserts a zero bubble.
module systolic_ctrl #(
  parameter int N         = 4,
  parameter int NUM_BITS  = 8,
  parameter int DRAIN_CYC = 2 * N
) (
  input  logic           clk,
  input  logic           rst,
  systolic_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int DRN_W = $clog2(DRAIN_CYC + 1);

  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(N - 1);
  localparam logic [DRN_W-1:0] LAST_DRAIN = DRN_W'(DRAIN_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                   state_q, state_d;
  logic [CNT_W-1:0]             beat_cnt_q, beat_cnt_d;
  logic [DRN_W-1:0]             drain_cnt_q, drain_cnt_d;
  logic                         clr_q, clr_d;
  logic [N-1:0][NUM_BITS-1:0]   north_q, north_d;

  logic b_acc;
  logic a_acc;

  // Beats are only taken while the matching phase owns the ready line.
  assign b_acc = (state_q == S_LOAD)   & bus.b_valid_i;
  assign a_acc = (state_q == S_STREAM) & bus.a_valid_i;

  // Phase sequencing, beat/drain counting, clear pulse and north capture.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    clr_d       = 1'b0;
    north_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d    = bus.reload_i ? S_LOAD : S_STREAM;
          clr_d      = ~bus.acc_i;
          beat_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (b_acc) begin
          north_d = bus.b_row_i;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = S_STREAM;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      S_STREAM: begin
        if (a_acc) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d  = '0;
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Skew registers keep shifting zeros out while the array finishes.
        if (drain_cnt_q == LAST_DRAIN) begin
          drain_cnt_d = '0;
          state_d     = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRN_W'(1);
        end
      end
      S_DONE: begin
        // start_i here is deliberately ignored; a new job needs an IDLE cycle.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      clr_q       <= 1'b0;
      north_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      clr_q       <= clr_d;
      north_q     <= north_d;
    end
  end

  // Per-lane delay lines: lane i is i+1 registers deep, zero injected on non-accept cycles.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [NUM_BITS-1:0] sr_q [i+1];
    logic [NUM_BITS-1:0] sr_d [i+1];

    // Shift every cycle so relative skew between lanes is never disturbed.
    always_comb begin
      sr_d[0] = a_acc ? bus.a_row_i[i] : '0;
      for (int k = 1; k <= i; k++) begin
        sr_d[k] = sr_q[k-1];
      end
    end

    // Delay line storage; reset flushes in-flight data.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) begin
          sr_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k <= i; k++) begin
          sr_q[k] <= sr_d[k];
        end
      end
    end

    assign bus.west_o[i] = sr_q[i];
  end

  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.b_ready_o   = (state_q == S_LOAD);
  assign bus.a_ready_o   = (state_q == S_STREAM);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.array_clr_o = clr_q;
  assign bus.north_o     = north_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: job-level reference model plus directed pins.
// Latency: model schedules north/west/clear into a cycle-indexed ring.
// Backpressure: random valid gaps on both row streams.
module tb_systolic_ctrl;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int D    = 2 * N;
  localparam int HIST = 8192;
  localparam int RING = 64;
  typedef logic [N-1:0][W-1:0] row_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  systolic_ctrl_if #(.N(N), .NUM_BITS(W)) bus ();
  systolic_ctrl #(.N(N), .NUM_BITS(W), .DRAIN_CYC(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a job is a count of B beats still owed, A beats owed, drain cycles owed.
  bit   job_on = 1'b0;
  int   loads_left = 0;
  int   a_left = 0;
  int   drain_left = 0;
  row_t ex_north [RING];
  row_t ex_west  [RING];
  bit   ex_clr   [RING];

  row_t h_north [HIST];
  row_t h_west  [HIST];
  bit   h_clr [HIST];
  bit   h_done [HIST];
  bit   h_busy [HIST];
  bit   h_ardy [HIST];
  bit   h_brdy [HIST];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic row_t ident(input int r);
    row_t v;
    v = '0;
    v[r] = W'(1);
    return v;
  endfunction

  function automatic row_t rand_row();
    row_t v;
    for (int i = 0; i < N; i++) v[i] = W'($urandom);
    return v;
  endfunction

  // kind: 0 done, 1 clear, 2 b_ready, 3 west non-zero
  function automatic int count_hist(input int kind, input int lo, input int hi);
    int n;
    n = 0;
    for (int c = lo; c <= hi; c++) begin
      if (c >= 0 && c < HIST) begin
        case (kind)
          0:       n += int'(h_done[c]);
          1:       n += int'(h_clr[c]);
          2:       n += int'(h_brdy[c]);
          default: n += int'(h_west[c] != '0);
        endcase
      end
    end
    return n;
  endfunction

  // Compare process: checks every cycle against the model, then advances the model.
  initial begin : monitor
    int  s;
    int  nx;
    bit  e_brdy;
    bit  e_ardy;
    bit  e_done;
    for (int k = 0; k < RING; k++) begin
      ex_north[k] = '0; ex_west[k] = '0; ex_clr[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < HIST) begin
        s  = cyc % RING;
        nx = (cyc + 1) % RING;
        e_brdy = job_on && loads_left > 0;
        e_ardy = job_on && loads_left == 0 && a_left > 0;
        e_done = job_on && loads_left == 0 && a_left == 0 && drain_left == 0;
        chk("busy_o", 64'(bus.busy_o), 64'(job_on));
        chk("b_ready_o", 64'(bus.b_ready_o), 64'(e_brdy));
        chk("a_ready_o", 64'(bus.a_ready_o), 64'(e_ardy));
        chk("done_o", 64'(bus.done_o), 64'(e_done));
        chk("array_clr_o", 64'(bus.array_clr_o), 64'(ex_clr[s]));
        chk("north_o", 64'(bus.north_o), 64'(ex_north[s]));
        chk("west_o", 64'(bus.west_o), 64'(ex_west[s]));
        ex_north[s] = '0; ex_west[s] = '0; ex_clr[s] = 1'b0;
        h_north[cyc] = bus.north_o;
        h_west[cyc]  = bus.west_o;
        h_clr[cyc]   = bus.array_clr_o;
        h_done[cyc]  = bus.done_o;
        h_busy[cyc]  = bus.busy_o;
        h_ardy[cyc]  = bus.a_ready_o;
        h_brdy[cyc]  = bus.b_ready_o;
        if (rst) begin
          job_on = 1'b0;
          for (int k = 0; k < RING; k++) begin
            ex_north[k] = '0; ex_west[k] = '0; ex_clr[k] = 1'b0;
          end
        end else if (!job_on) begin
          if (bus.start_i) begin
            job_on     = 1'b1;
            loads_left = bus.reload_i ? N : 0;
            a_left     = N;
            drain_left = D;
            ex_clr[nx] = !bus.acc_i;
          end
        end else if (loads_left > 0) begin
          if (bus.b_valid_i) begin
            ex_north[nx] = bus.b_row_i;
            loads_left--;
          end
        end else if (a_left > 0) begin
          if (bus.a_valid_i) begin
            for (int i = 0; i < N; i++) ex_west[(cyc + 1 + i) % RING][i] = bus.a_row_i[i];
            a_left--;
          end
        end else if (drain_left > 0) begin
          drain_left--;
        end else begin
          job_on = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input row_t row, input bit rnd, output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    for (int t = 0; t < 200 && !got; t++) begin
      bus.b_valid_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.b_row_i   = bus.b_valid_i ? row : rand_row();
      @(negedge clk);
      if (bus.b_valid_i && bus.b_ready_o) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
      tick();
    end
    bus.b_valid_i = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL b_accept: no handshake within 200 cycles, one required");
    end
  endtask

  task automatic send_a(input row_t row, input bit rnd, output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    for (int t = 0; t < 200 && !got; t++) begin
      bus.a_valid_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.a_row_i   = bus.a_valid_i ? row : rand_row();
      @(negedge clk);
      if (bus.a_valid_i && bus.a_ready_o) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
      tick();
    end
    bus.a_valid_i = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL a_accept: no handshake within 200 cycles, one required");
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int t = 0; t < 200 && dc < 0; t++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) dc = cyc;
      tick();
    end
    if (dc < 0) begin
      n_total++;
      $display("FAIL done_wait: done_o not seen within 200 cycles, one pulse required");
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({tag, "_b_ready"}, 64'(bus.b_ready_o), 64'd0);
    chk({tag, "_a_ready"}, 64'(bus.a_ready_o), 64'd0);
    chk({tag, "_done"}, 64'(bus.done_o), 64'd0);
    chk({tag, "_clr"}, 64'(bus.array_clr_o), 64'd0);
    chk({tag, "_north"}, 64'(bus.north_o), 64'd0);
    chk({tag, "_west"}, 64'(bus.west_o), 64'd0);
  endtask

  initial begin : driver
    int          s;
    int          dc;
    int          dc2;
    int          q;
    int          tmp;
    bit          rl;
    int          bc [N];
    int          ac [N];
    logic [31:0] n_exp [N];
    int          off_b2b [N];
    int          off_gap [N];
    logic [31:0] one;

    n_exp   = '{32'h0100_0000, 32'h0001_0000, 32'h0000_0100, 32'h0000_0001};
    off_b2b = '{1, 3, 5, 7};
    off_gap = '{1, 3, 7, 9};
    one     = 32'h1;

    rst = 1'b1;
    bus.start_i = 1'b0; bus.reload_i = 1'b0; bus.acc_i = 1'b0;
    bus.b_valid_i = 1'b0; bus.b_row_i = '0;
    bus.a_valid_i = 1'b0; bus.a_row_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    tick();

    // Load identity B (rows 3..0), stream identity A back-to-back.
    s = cyc;
    bus.start_i = 1'b1; bus.reload_i = 1'b1; bus.acc_i = 1'b0;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < N; k++) send_b(ident(N - 1 - k), 1'b0, bc[k]);
    for (int k = 0; k < N; k++) send_a(ident(k), 1'b0, ac[k]);
    wait_done(dc);
    repeat (3) tick();
    chk("j1_clr_pulse", 64'(h_clr[s + 1]), 64'd1);
    chk("j1_clr_count", 64'(count_hist(1, s, dc)), 64'd1);
    for (int k = 0; k < N; k++) chk("j1_north_pin", 64'(h_north[bc[k] + 1]), 64'(n_exp[k]));
    chk("j1_stream_after_b", 64'(h_ardy[bc[N-1] + 1]), 64'd1);
    for (int k = 0; k < N; k++) chk("j1_west_pin", 64'(h_west[ac[0] + off_b2b[k]]), 64'(one << (8 * k)));
    chk("j1_west_count", 64'(count_hist(3, ac[0], dc)), 64'd4);
    chk("j1_done_from_last_a", 64'(dc - ac[N-1]), 64'd9);
    chk("j1_done_from_first_a", 64'(dc - ac[0]), 64'd12);
    chk("j1_done_count", 64'(count_hist(0, s, dc + 3)), 64'd1);

    // Reuse weights, accumulate, 2-cycle bubble between rows 1 and 2.
    s = cyc;
    bus.start_i = 1'b1; bus.reload_i = 1'b0; bus.acc_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    send_a(ident(0), 1'b0, ac[0]);
    send_a(ident(1), 1'b0, ac[1]);
    tick();
    tick();
    send_a(ident(2), 1'b0, ac[2]);
    send_a(ident(3), 1'b0, ac[3]);
    wait_done(dc);
    repeat (2) tick();
    chk("j2_a_ready_first", 64'(h_ardy[s + 1]), 64'd1);
    chk("j2_first_a_cycle", 64'(ac[0] - s), 64'd1);
    chk("j2_no_clr", 64'(count_hist(1, s, dc)), 64'd0);
    chk("j2_no_b_ready", 64'(count_hist(2, s, dc)), 64'd0);
    for (int k = 0; k < N; k++) chk("j2_west_pin", 64'(h_west[ac[0] + off_gap[k]]), 64'(one << (8 * k)));
    chk("j2_west_count", 64'(count_hist(3, ac[0], dc)), 64'd4);
    chk("j2_done_from_first_a", 64'(dc - ac[0]), 64'd14);

    // Reset after two A beats, restart on the very next cycle.
    bus.start_i = 1'b1; bus.reload_i = 1'b1; bus.acc_i = 1'b0;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < N; k++) send_b(rand_row(), 1'b0, tmp);
    send_a(rand_row(), 1'b0, tmp);
    send_a(rand_row(), 1'b0, tmp);
    q = cyc;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.start_i = 1'b1; bus.reload_i = 1'b1; bus.acc_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < N; k++) send_b(rand_row(), 1'b1, tmp);
    for (int k = 0; k < N; k++) send_a(rand_row(), 1'b1, tmp);
    wait_done(dc);
    chk("j3_restart_busy", 64'(h_busy[q + 2]), 64'd1);
    chk("j3_restart_load", 64'(h_brdy[q + 2]), 64'd1);
    tick();

    // start_i held high across a whole job.
    s = cyc;
    bus.start_i = 1'b1; bus.reload_i = 1'b0; bus.acc_i = 1'b0;
    tick();
    for (int k = 0; k < N; k++) send_a(rand_row(), 1'b1, tmp);
    wait_done(dc);
    tick();
    tick();
    bus.start_i = 1'b0;
    chk("j4_idle_after_done", 64'(h_busy[dc + 1]), 64'd0);
    chk("j4_restart_from_idle", 64'(h_busy[dc + 2]), 64'd1);
    chk("j4_restart_clr", 64'(h_clr[dc + 2]), 64'd1);
    chk("j4_single_done", 64'(count_hist(0, s, dc + 2)), 64'd1);
    for (int k = 0; k < N; k++) send_a(rand_row(), 1'b1, tmp);
    wait_done(dc2);
    chk("j4_second_done_count", 64'(count_hist(0, dc + 1, dc2)), 64'd1);
    tick();

    // Randomized jobs with stray control toggles while busy.
    for (int j = 0; j < 25; j++) begin
      rl = 1'($urandom_range(0, 1));
      bus.start_i = 1'b1; bus.reload_i = rl; bus.acc_i = 1'($urandom_range(0, 1));
      tick();
      bus.start_i  = 1'($urandom_range(0, 1));
      bus.reload_i = 1'($urandom_range(0, 1));
      bus.acc_i    = 1'($urandom_range(0, 1));
      if (rl) for (int k = 0; k < N; k++) send_b(rand_row(), 1'b1, tmp);
      for (int k = 0; k < N; k++) send_a(rand_row(), 1'b1, tmp);
      bus.start_i = 1'b0;
      wait_done(dc);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
